// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : AHB-Lite transfer/size/response codes and RAM slave states.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ram_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_lite_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_ram_array
// Description : MEM_WORDS x 32 storage, async read, byte-enable sync write.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_ram_array #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];

    // Contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/ahb_lite_ram.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_ram
// Description : AHB-Lite slave RAM with wait states and two-cycle ERROR.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_ram
    import ahb_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    localparam int         c_aw        = $clog2(MEM_WORDS);
    localparam int         c_ow        = c_aw + 2;
    localparam logic [1:0] c_wait_load = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    ram_state_t      r_state, w_state_nxt;
    logic [1:0]      r_wait_cnt, w_wait_cnt_nxt;
    logic            r_dp_valid, w_dp_valid_nxt;
    logic            r_dp_write;
    logic [3:0]      r_dp_be;
    logic [c_aw-1:0] r_dp_idx;

    logic            w_accept, w_legal, w_load, w_dp_done;
    logic [3:0]      w_be, w_mem_be;
    logic [31:0]     w_mem_rdata;
    logic            w_unused_haddr;

    assign w_unused_haddr = ^{HADDR[31:c_ow], HTRANS[0]};
    assign w_accept       = HSEL & HTRANS[1] & HREADY;

    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        case (HSIZE)
            HSIZE_BYTE: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << HADDR[1:0];
            end
            HSIZE_HALF: begin
                w_legal = ~HADDR[0];
                w_be    = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            HSIZE_WORD: begin
                w_legal = (HADDR[1:0] == 2'b00);
                w_be    = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
                w_be    = 4'b0000;
            end
        endcase
    end

    // IDLE and ERR2 both end a data phase, so both may take a new address phase
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_dp_valid_nxt = r_dp_valid;
        w_load         = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_dp_valid_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
                if (w_accept) begin
                    if (w_legal) begin
                        w_load         = 1'b1;
                        w_dp_valid_nxt = 1'b1;
                        if (WAIT_STATES > 0) begin
                            w_state_nxt    = ST_WAIT;
                            w_wait_cnt_nxt = c_wait_load;
                        end
                    end else begin
                        w_state_nxt = ST_ERR1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 2'd1;
                end
            end
            ST_ERR1: begin
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 2'd0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_be    <= 4'b0000;
            r_dp_idx   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_dp_valid <= w_dp_valid_nxt;
            if (w_load) begin
                r_dp_write <= HWRITE;
                r_dp_be    <= w_be;
                r_dp_idx   <= HADDR[c_ow-1:2];
            end
        end
    end

    // OKAY data phase completes in IDLE with a transfer still pending
    assign w_dp_done = r_dp_valid & (r_state == ST_IDLE);
    assign w_mem_be  = (w_dp_done & r_dp_write) ? r_dp_be : 4'b0000;

    assign HREADYOUT = (r_state == ST_IDLE) | (r_state == ST_ERR2);
    assign HRESP     = ((r_state == ST_ERR1) | (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (w_dp_done & ~r_dp_write) ? w_mem_rdata : 32'h0;

    ahb_lite_ram_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (c_aw)
    ) u_array (
        .clk     (HCLK),
        .i_be    (w_mem_be),
        .i_addr  (r_dp_idx),
        .i_wdata (HWDATA),
        .o_rdata (w_mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_ram
// Description : Directed self-checking bench; one slave with 1 wait, one with 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_ram;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel, hwrite, use0, block;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;

    logic        ro1, rs1, ro0, rs0;
    logic [31:0] rd1, rd0;
    logic        hready_bus, ro, rs;
    logic [31:0] rd;
    logic        hsel1, hsel0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign hsel1      = hsel & ~use0;
    assign hsel0      = hsel & use0;
    assign ro         = use0 ? ro0 : ro1;
    assign rs         = use0 ? rs0 : rs1;
    assign rd         = use0 ? rd0 : rd1;
    assign hready_bus = block ? 1'b0 : ro;

    ahb_lite_ram #(.MEM_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(ro1), .HRDATA(rd1), .HRESP(rs1)
    );

    ahb_lite_ram #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(rs0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single non-pipelined transfer; entered and left 1 time unit after an edge
    task automatic xfer(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int stalls, output logic resp_first, output logic resp_last);
        int guard;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hsize = size; hwrite = wr;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
        stalls = 0; guard = 0; resp_first = rs;
        while (ro !== 1'b1 && guard < 16) begin
            stalls++; guard++;
            @(posedge clk); #1;
        end
        if (guard >= 16) begin
            n_assert++; n_fail++;
            $error("FAIL timeout: HREADYOUT stuck low at addr %h", addr);
        end
        rdata = rd; resp_last = rs;
        @(posedge clk); #1;
    endtask

    logic [31:0] rdat;
    int          st;
    logic        rf, rl;

    initial begin
        rst = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hsize = HSIZE_WORD;
        hwrite = 1'b0; hwdata = '0; use0 = 1'b0; block = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready1", 32'(ro1), 32'd1);
        check("rst_resp1",  32'(rs1), 32'd0);
        check("rst_rdata1", rd1, 32'h0);
        check("rst_ready0", 32'(ro0), 32'd1);
        check("rst_resp0",  32'(rs0), 32'd0);
        check("rst_rdata0", rd0, 32'h0);

        xfer(32'h10, HSIZE_WORD, 1'b1, 32'hDEADBEEF, rdat, st, rf, rl);
        check("wr10_stalls", 32'(st), 32'd1);
        check("wr10_resp",   32'(rl), 32'd0);
        xfer(32'h10, HSIZE_WORD, 1'b0, 32'h0, rdat, st, rf, rl);
        check("rd10_stalls", 32'(st), 32'd1);
        check("rd10_data",   rdat, 32'hDEADBEEF);

        // Replicated write data exposes any wrong byte-enable lane
        xfer(32'h10, HSIZE_WORD, 1'b1, 32'h00000000, rdat, st, rf, rl);
        xfer(32'h13, HSIZE_BYTE, 1'b1, 32'hAAAAAAAA, rdat, st, rf, rl);
        xfer(32'h10, HSIZE_HALF, 1'b1, 32'h55665566, rdat, st, rf, rl);
        xfer(32'h10, HSIZE_WORD, 1'b0, 32'h0, rdat, st, rf, rl);
        check("lanes_data", rdat, 32'hAA005566);

        xfer(32'h00, HSIZE_WORD, 1'b1, 32'hCAFEF00D, rdat, st, rf, rl);
        xfer(32'h02, HSIZE_WORD, 1'b0, 32'h0, rdat, st, rf, rl);
        check("mis_rd_stalls", 32'(st), 32'd1);
        check("mis_rd_resp1",  32'(rf), 32'd1);
        check("mis_rd_resp2",  32'(rl), 32'd1);
        check("mis_rd_data",   rdat, 32'h0);
        xfer(32'h02, HSIZE_WORD, 1'b1, 32'hFFFFFFFF, rdat, st, rf, rl);
        check("mis_wr_resp", 32'(rl), 32'd1);
        xfer(32'h01, HSIZE_HALF, 1'b1, 32'hFFFFFFFF, rdat, st, rf, rl);
        check("mis_half_resp", 32'(rl), 32'd1);
        xfer(32'h00, 3'd3, 1'b1, 32'hFFFFFFFF, rdat, st, rf, rl);
        check("bad_size_resp", 32'(rl), 32'd1);
        xfer(32'h00, HSIZE_WORD, 1'b0, 32'h0, rdat, st, rf, rl);
        check("err_mem_kept", rdat, 32'hCAFEF00D);
        check("ok_after_err", 32'(rl), 32'd0);

        // Address phase while the bus is stalled elsewhere must be ignored
        block = 1'b1; hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h00;
        hsize = HSIZE_WORD; hwrite = 1'b1;
        @(posedge clk); #1;
        block = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h11111111;
        check("hready_block", 32'(ro1), 32'd1);
        @(posedge clk); #1;
        xfer(32'h00, HSIZE_WORD, 1'b0, 32'h0, rdat, st, rf, rl);
        check("hready_block_mem", rdat, 32'hCAFEF00D);

        // Zero-wait slave: pipelined write then read of the same word
        use0 = 1'b1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hsize = HSIZE_WORD; hwrite = 1'b1;
        @(posedge clk); #1;
        check("b2b_wr_ready", 32'(ro), 32'd1);
        hwdata = 32'h12345678; hwrite = 1'b0;
        @(posedge clk); #1;
        check("b2b_rd_ready", 32'(ro), 32'd1);
        check("b2b_rd_resp",  32'(rs), 32'd0);
        check("b2b_rd_data",  rd, 32'h12345678);
        hsel = 1'b0; htrans = HTRANS_IDLE;
        @(posedge clk); #1;
        use0 = 1'b0;

        // Reset during the wait state of a write discards it
        xfer(32'h30, HSIZE_WORD, 1'b1, 32'h0BADC0DE, rdat, st, rf, rl);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hsize = HSIZE_WORD; hwrite = 1'b1;
        @(posedge clk); #1;
        check("rst_wait_stall", 32'(ro1), 32'd0);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ready", 32'(ro1), 32'd1);
        check("rst_mid_resp",  32'(rs1), 32'd0);
        check("rst_mid_rdata", rd1, 32'h0);
        @(posedge clk); #1;
        xfer(32'h30, HSIZE_WORD, 1'b0, 32'h0, rdat, st, rf, rl);
        check("rst_mid_mem", rdat, 32'h0BADC0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
